reg_file: RTL

//   32 x 32-bit integer register file. It supplies ReadData1/ReadData2 operands to the ALU.
//   It accepts the ALU result (or load data) as WriteData for write-back.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/reg_file_if.sv | 27 ++
 rtl/reg_file.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry, instruction field positions
// and the register-file init sequencer state encoding.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;

  // Bit positions of the register fields inside the instruction word
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  // Hard-wired zero register
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Init sequencer states
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/reg_file_if.sv
// Register-file port bundle between the core (master) and the register file (slave).
//
// Handshake: there is no valid/ready pair. The register file raises busy while it
// zeroes its storage; the core must stall and any RegWrite presented while busy=1
// is dropped (not queued). Reads are combinational from instruction; a write is
// taken on the rising clock edge whenever RegWrite=1 and busy=0.
interface reg_file_if #(
  parameter int XLEN = cpu_pkg::XLEN
);
  logic [31:0]     instruction;
  logic            RegWrite;
  logic [XLEN-1:0] WriteData;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic            busy;
  logic [0:0]      dbg_state;   // init sequencer state, for observation only

  modport master (
    output instruction, RegWrite, WriteData,
    input  ReadData1, ReadData2, busy, dbg_state
  );

  modport slave (
    input  instruction, RegWrite, WriteData,
    output ReadData1, ReadData2, busy, dbg_state
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file: NREGS x XLEN, two combinational read ports, one
// synchronous write port. After reset an init sequencer zeroes one entry per
// cycle so the array itself carries no reset and can map to distributed RAM.
module reg_file #(
  parameter int NREGS  = 32,
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter bit BYPASS = 1'b0   // write-first forwarding; keep 0 in the single-cycle core
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave rf
);
  import cpu_pkg::*;

  localparam int            AW   = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic [XLEN-1:0] mem [NREGS];

  logic [AW-1:0]   rs1, rs2, rd;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] rd_data1, rd_data2;

  // Instruction bits outside the register fields are decoded elsewhere
  logic            unused_instr;

  assign rs1          = rf.instruction[RS1_LSB +: AW];
  assign rs2          = rf.instruction[RS2_LSB +: AW];
  assign rd           = rf.instruction[RD_LSB +: AW];
  assign unused_instr = ^rf.instruction;

  // Init sequencer: walk cnt over every entry once, then park in RUN until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
    busy_d = (state_d == INIT);
  end

  // Sequencer state; busy comes straight from a flop so the stall path is clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Write port mux: init zeroing owns the port while INIT, write-back afterwards
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_data = '0;
    if (state_q == INIT) begin
      wr_en = 1'b1;
    end else if (rf.RegWrite && (rd != ZERO)) begin
      wr_en   = 1'b1;
      wr_addr = rd;
      wr_data = rf.WriteData;
    end
  end

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports: optional forwarding, x0 reads zero, everything reads zero while busy
  always_comb begin
    rd_data1 = mem[rs1];
    rd_data2 = mem[rs2];
    if (BYPASS && rf.RegWrite && !busy_q && (rd != ZERO)) begin
      if (rd == rs1) rd_data1 = rf.WriteData;
      if (rd == rs2) rd_data2 = rf.WriteData;
    end
    if (rs1 == ZERO) rd_data1 = '0;
    if (rs2 == ZERO) rd_data2 = '0;
    if (busy_q) begin
      rd_data1 = '0;
      rd_data2 = '0;
    end
  end

  assign rf.ReadData1 = rd_data1;
  assign rf.ReadData2 = rd_data2;
  assign rf.busy      = busy_q;
  assign rf.dbg_state = state_q;

endmodule
